// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
// Segment codes are active-low, bit order gfedcba.
package disp_pkg;

  typedef enum logic {
    BLANK,
    SHOW
  } scan_state_t;

  localparam logic [7:0] ANODES_OFF = 8'hFF;
  localparam logic [6:0] SEG_OFF    = 7'h7F;

  // Entry n is the glyph for hex digit n (F first in the concatenation).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Hex nibble to active-low 7-segment glyph.
// Purely combinational table lookup.
module seg7_hex_decoder
  import disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/display_scan_scheduler.sv
// 8-digit common-anode display scanner with blanking gap,
// leading-zero suppression and tear-free frame-boundary data commit.
module display_scan_scheduler
  import disp_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic [7:0]  load_dp,
  input  logic [7:0]  digit_en,
  input  logic        lzb_en,
  output logic        load_ready,
  output logic [7:0]  anodes,
  output logic [6:0]  segments,
  output logic        dp_n,
  output logic [2:0]  digit_idx,
  output logic        frame_done
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_FIRST = CW'(BLANK_CYCLES);

  scan_state_t   state_q, state_d;
  logic [CW-1:0] slot_q, slot_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   act_data_q, act_data_d;
  logic [7:0]    act_dp_q, act_dp_d;
  logic [31:0]   pend_data_q;
  logic [7:0]    pend_dp_q;
  logic          ready_q;
  logic [7:0]    anodes_q, anodes_d;
  logic [6:0]    seg_q, seg_d;
  logic          dpn_q, dpn_d;
  logic          fd_q;

  logic          wrap, boundary, xfer, commit;
  logic          lz, dark;
  logic [3:0]    nib;
  logic [6:0]    glyph;

  seg7_hex_decoder u_dec (
    .nibble_i (nib),
    .seg_n_o  (glyph)
  );

  always_comb begin
    wrap     = (slot_q == SLOT_LAST);
    boundary = wrap && (idx_q == 3'd7);
    xfer     = load_valid && ready_q;
    commit   = boundary && !ready_q;

    slot_d = wrap ? '0 : slot_q + 1'b1;
    idx_d  = wrap ? idx_q + 3'd1 : idx_q;

    state_d = state_q;
    unique case (state_q)
      BLANK: if (slot_d == SHOW_FIRST) state_d = SHOW;
      SHOW:  if (wrap)                 state_d = BLANK;
      default: state_d = BLANK;
    endcase

    act_data_d = commit ? pend_data_q : act_data_q;
    act_dp_d   = commit ? pend_dp_q   : act_dp_q;

    // Outputs are computed for the slot about to begin so the
    // registered pins line up with slot_cnt and digit_idx.
    nib  = act_data_d[{idx_d, 2'b00} +: 4];
    lz   = (idx_d != 3'd0)
        && ((act_data_d >> {idx_d, 2'b00}) == 32'd0)
        && !act_dp_d[idx_d];
    dark = (state_d == BLANK)
        || !digit_en[idx_d]
        || (lzb_en && lz);

    anodes_d = dark ? ANODES_OFF : ~(8'd1 << idx_d);
    seg_d    = dark ? SEG_OFF : glyph;
    dpn_d    = dark ? 1'b1 : ~act_dp_d[idx_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BLANK;
      slot_q      <= '0;
      idx_q       <= '0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      ready_q     <= 1'b1;
      anodes_q    <= ANODES_OFF;
      seg_q       <= SEG_OFF;
      dpn_q       <= 1'b1;
      fd_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      idx_q      <= idx_d;
      act_data_q <= act_data_d;
      act_dp_q   <= act_dp_d;
      anodes_q   <= anodes_d;
      seg_q      <= seg_d;
      dpn_q      <= dpn_d;
      fd_q       <= boundary;
      if (xfer) begin
        pend_data_q <= load_data;
        pend_dp_q   <= load_dp;
        ready_q     <= 1'b0;
      end else if (commit) begin
        ready_q     <= 1'b1;
      end
    end
  end

  assign load_ready = ready_q;
  assign anodes     = anodes_q;
  assign segments   = seg_q;
  assign dp_n       = dpn_q;
  assign digit_idx  = idx_q;
  assign frame_done = fd_q;

endmodule

// File: doc/display_scan_scheduler.md
Name: display_scan_scheduler

Overview:
- Time-multiplexes an 8-digit, common-anode 7-segment display (active-low anodes and segments).
- Sequences the digit select with a programmable dwell time and an inter-digit blanking gap for ghosting suppression.
- Accepts new 32-bit hex display data through a valid/ready handshake and commits it only at frame boundaries, so a displayed frame never tears.
- Sits between application logic (counters, calculators) and the board display pins.

Parameters:
- DIGIT_CYCLES, 100000, total clk cycles per digit slot, blank gap included; must be >= 2.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must satisfy 1 <= BLANK_CYCLES < DIGIT_CYCLES.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- load_valid  input  1  new display data offered.
- load_data  input  32  eight hex nibbles; nibble i (bits 4i+3..4i) drives digit i.
- load_dp  input  8  decimal point per digit, 1 = lit.
- digit_en  input  8  per-digit enable, sampled live; 0 forces that digit off.
- lzb_en  input  1  leading-zero blanking enable, sampled live.
- load_ready  output  1  scheduler can accept data.
- anodes  output  8  active-low digit selects; bit i = digit i.
- segments  output  7  active-low; bit 0 = CA ... bit 6 = CG.
- dp_n  output  1  active-low decimal point.
- digit_idx  output  3  digit currently scanned.
- frame_done  output  1  one-cycle pulse at each frame start.

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered (Moore); no combinational path from inputs to outputs.
- Reset values: anodes=8'hFF, segments=7'h7F, dp_n=1, digit_idx=0, frame_done=0, load_ready=1, slot_cnt=0, FSM=BLANK, active data/dp=0, pending register empty.
- Reset mid-frame or mid-handshake discards pending data and restarts the scan at digit 0, slot cycle 0.
- FSM states: BLANK, SHOW.
  - BLANK: held while slot_cnt < BLANK_CYCLES; anodes=FF, segments=7F, dp_n=1.
  - SHOW: held for the remaining DIGIT_CYCLES-BLANK_CYCLES cycles.
- Slot counter: slot_cnt counts 0..DIGIT_CYCLES-1 and wraps.
  - On wrap, digit_idx increments modulo 8 (7->0) and FSM returns to BLANK.
- SHOW output:
  - anodes = all ones except bit digit_idx = 0.
  - segments = hex encoding of the active nibble.
  - dp_n = ~active_dp[digit_idx].
- SHOW is forced dark (anodes=FF, segments=7F, dp_n=1) when either:
  - digit_en[digit_idx]=0, or
  - lzb_en=1, digit_idx!=0, active nibbles digit_idx..7 are all zero, and active_dp[digit_idx]=0.
  - Digit 0 is never LZ-blanked.
- Hex encoding (active-low, gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Handshake:
  - A transfer occurs when load_valid && load_ready at a rising edge.
  - On transfer, data/dp are captured into the pending register and load_ready goes 0 the next cycle.
- Frame boundary (slot_cnt==DIGIT_CYCLES-1 and digit_idx==7):
  - If pending, active <= pending at that edge and pending clears.
  - load_ready returns to 1 on the same edge.
  - frame_done=1 for exactly the first cycle of digit 0 (slot_cnt==0).
- Simultaneous transfer and boundary: cannot occur with stale data, because load_ready=1 implies nothing is pending. The new data is captured to pending and commits at the next boundary (one full frame later).
- load_valid held without ready: no effect; the producer holds its data until ready.

Decomposition:
- Shared package disp_pkg holds:
  - typedef enum {BLANK, SHOW} scan_state_t;
  - constants ANODES_OFF=8'hFF, SEG_OFF=7'h7F;
  - the 16-entry hex segment constant table.
- Natural sub-module: seg7_hex_decoder (4-bit nibble -> 7-bit active-low segments, combinational), instantiated once.
- Anode one-cold decode stays inline.

Test Plan (DIGIT_CYCLES=4, BLANK_CYCLES=1 unless stated):
- Reset for 3 cycles, then release. Required:
  - outputs hold reset values during reset;
  - cycle 0 after release: BLANK, anodes=FF;
  - cycles 1-3: anodes=FE, segments=40 (digit 0 shows 0);
  - digit_idx steps 0..7 every 4 cycles;
  - frame_done pulses every 32 cycles.
- Load 32'h89ABCDEF, dp=8'h01, mid-frame. Required:
  - load_ready drops the next cycle;
  - current frame still shows old data;
  - the frame after frame_done shows digit0 segments=0E with dp_n=0, digit7 segments=00;
  - load_ready=1 from the first cycle of the new frame.
- Hold load_valid while load_ready=0 with changing data. Required: only the first accepted word appears; the second is accepted after ready rises and displays one frame later.
- lzb_en=1, load 32'h00000050. Required:
  - digits 2..7 stay dark (anodes=FF during their SHOW);
  - digit1 shows 5 (12); digit0 shows 0 (40).
  - Same load with dp=8'h80: digit 7 lights and shows 0 with its dp, while digits 2..6 stay dark.
- digit_en=8'b11110111. Required: digit 3 slot is all-off for all 4 cycles while other digits scan normally; re-enabling takes effect within one cycle.
- Assert reset during digit 5 with a pending load. Required: next cycle digit_idx=0, BLANK, load_ready=1, active data=0, pending data never displayed.
